load_store_unit: RTL and testbench
==================================

// Module: load_store_unit
// PURPOSE
//  MEM-stage initiator for the data-memory controller. Takes load/store requests from the pipeline,
//  aligns store data and generates byte-lane enables. Drives and holds the memory request until
//  mem_ready completes it, then sign/zero-extends load data and releases the pipeline stall.
//  Detects misaligned or illegal accesses and bounds every access with a timeout.
// PARAMETERS
//  TIMEOUT_CYCLES  64  max WAIT-state cycles before bus_error; counter width = $clog2(TIMEOUT_CYCLES+1)
// PORTS
//  clk             in   1   single clock, rising edge
//  reset           in   1   asynchronous, active-low reset
//  req_ren         in   1   pipeline load request (level, sampled in IDLE)
//  req_wen         in   1   pipeline store request (level, sampled in IDLE)
//  req_funct3      in   3   RV32I width/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
//  req_addr        in   32  byte address
//  req_wdata       in   32  store data, right-justified
//  stall           out  1   hold pipeline; high while an accepted access is outstanding
//  done            out  1   1-cycle pulse: access finished (data/err valid this cycle)
//  load_data       out  32  extended load result, held until next done
//  misalign        out  1   1-cycle pulse: misaligned/illegal request rejected
//  bus_error       out  1   1-cycle pulse with done: timeout expired
//  mem_address     out  32  to controller: word address (req_addr with [1:0] cleared)
//  mem_datain      out  32  to controller: lane-replicated store data
//  mem_ren         out  1   to controller: read enable
//  mem_wen         out  1   to controller: write enable
//  mem_byte_select out  4   to controller: lane enables, bit i = byte i
//  mem_ready       in   1   from controller: 0 = busy (miss in progress)
//  mem_dataout     in   32  from controller: read word
// BEHAVIOUR
//  Reset (async, reset=0): state IDLE, all outputs 0, timeout counter 0. mem_ren/mem_wen drop immediately.
//   An access interrupted mid-flight is abandoned; no done.
//  States: IDLE -> ISSUE -> WAIT -> DONE -> IDLE.
//  IDLE: if req_ren^req_wen and the request is legal, latch addr/funct3/data/dir, go ISSUE, stall=1.
//   - If illegal: misalign=1 for one cycle, stay IDLE, stall=0, no memory access.
//   - Illegal = ren&wen both set, funct3 in {011,110,111}, store funct3 in {100,101}, H with addr[0]=1, W with addr[1:0]!=0.
//  ISSUE: memory signals driven from latched request; mem_ready ignored this cycle. Go WAIT.
//  WAIT: memory signals held stable. Counter increments each cycle.
//   - On mem_ready=1, capture/extend mem_dataout (loads), go DONE.
//   - If counter reaches TIMEOUT_CYCLES with mem_ready=0: bus_error=1, go DONE, load_data unchanged.
//  DONE: done=1, stall=0, mem_ren/mem_wen=0, counter cleared. Go IDLE. A new request is accepted the following cycle.
//  Min latency: request seen in IDLE at edge N; done high in cycle N+3 (ready already 1 in WAIT).
//  Byte select, with o = addr[1:0]:
//   - B: 4'b0001<<o. H: 4'b0011<<o. W: 4'b1111.
//  Store data lanes:
//   - B: {4{wdata[7:0]}}. H: {2{wdata[15:0]}}. W: wdata.
//  Load extract: word >> (8*o), then extend to 32 bits.
//   - B/H: sign-extended from bit 7/15.
//   - BU/HU: zero-extended.
//  stall is Moore (from state), not combinational from mem_ready.
// STRUCTURE
//  Shared include lsu_defs.vh: funct3 localparams (F3_LB..F3_LHU), state encodings (2-bit), lane masks.
//  Sub-module lsu_align: combinational legality check, byte_select generation,
//   store replication and load extract/extend. The FSM, counter and request latches stay in load_store_unit.
// TESTING
//  1. SW addr 0x100 data 0xDEADBEEF, mem_ready=1 -> mem_wen=1, sel 1111, mem_datain 0xDEADBEEF, done at N+3.
//  2. LB addr 0x103, mem_dataout 0x80FF0000 -> sel 1000, load_data 0xFFFFFF80.
//     LBU same -> 0x00000080.
//  3. LH addr 0x102, mem_ready low 5 WAIT cycles, mem_dataout 0x8001xxxx -> stall held 7 cycles,
//     address/sel 1100 stable, load_data 0xFFFF8001.
//  4. LW addr 0x101 -> misalign pulse, stall=0, mem_ren never asserted.
//     ren&wen both set -> same response.
//  5. LW with mem_ready stuck 0 -> bus_error and done at WAIT cycle TIMEOUT_CYCLES (64), stall released.
//  6. Assert reset during WAIT -> mem_ren/stall to 0 without clock edge.
//     After release, SB addr 0x2 data 0xAB -> sel 0100, datain 0xABABABAB.

Source files
------------

// File: rtl/load_store_unit_pkg.sv
// rtl/load_store_unit_pkg.sv - shared types and constants for the load/store unit
// Purpose: FSM state encoding, RV32I funct3 width/sign codes and byte-lane masks
//          shared by the LSU top and its alignment helper.
package load_store_unit_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  localparam logic [3:0] LANE_B = 4'b0001;
  localparam logic [3:0] LANE_H = 4'b0011;
  localparam logic [3:0] LANE_W = 4'b1111;

endpackage

// File: rtl/load_store_unit_if.sv
// rtl/load_store_unit_if.sv - data-memory controller request/response bus
// Purpose: groups the LSU <-> memory controller signals.
// Ports (signals):
//   mem_address/mem_datain/mem_ren/mem_wen/mem_byte_select : LSU -> controller
//   mem_ready/mem_dataout                                  : controller -> LSU
interface load_store_unit_if;
  logic [31:0] mem_address;
  logic [31:0] mem_datain;
  logic        mem_ren;
  logic        mem_wen;
  logic [3:0]  mem_byte_select;
  logic        mem_ready;
  logic [31:0] mem_dataout;

  modport master (
    output mem_address, mem_datain, mem_ren, mem_wen, mem_byte_select,
    input  mem_ready, mem_dataout
  );

  modport slave (
    input  mem_address, mem_datain, mem_ren, mem_wen, mem_byte_select,
    output mem_ready, mem_dataout
  );
endinterface

// File: rtl/load_store_unit_align.sv
// rtl/load_store_unit_align.sv - combinational legality, lane and extend logic
// Purpose: checks a pipeline request for legality, builds its byte-lane
//          enables and lane-replicated store data, and extracts/extends the
//          returned word for the latched load.
// Ports:
//   ren, wen, funct3, offset, wdata : live pipeline request (offset = addr[1:0])
//   ld_funct3, ld_offset, rdata     : latched load attributes and memory read word
//   legal, byte_select, store_data  : request decode
//   load_result                     : extracted and extended load value
module load_store_unit_align
  import load_store_unit_pkg::*;
(
  input  logic        ren,
  input  logic        wen,
  input  logic [2:0]  funct3,
  input  logic [1:0]  offset,
  input  logic [31:0] wdata,
  input  logic [2:0]  ld_funct3,
  input  logic [1:0]  ld_offset,
  input  logic [31:0] rdata,
  output logic        legal,
  output logic [3:0]  byte_select,
  output logic [31:0] store_data,
  output logic [31:0] load_result
);

  logic [31:0] shifted;

  always_comb begin
    legal = ren ^ wen;
    case (funct3)
      F3_LB, F3_LBU: legal = legal;
      F3_LH, F3_LHU: if (offset[0]) legal = 1'b0;
      F3_LW:         if (offset != 2'b00) legal = 1'b0;
      default:       legal = 1'b0;
    endcase
    // Unsigned variants have no store counterpart.
    if (wen && funct3[2]) legal = 1'b0;
  end

  always_comb begin
    case (funct3[1:0])
      2'b00: begin
        byte_select = LANE_B << offset;
        store_data  = {4{wdata[7:0]}};
      end
      2'b01: begin
        byte_select = LANE_H << offset;
        store_data  = {2{wdata[15:0]}};
      end
      default: begin
        byte_select = LANE_W;
        store_data  = wdata;
      end
    endcase
  end

  always_comb begin
    shifted = rdata >> {ld_offset, 3'b000};
    case (ld_funct3)
      F3_LB:   load_result = {{24{shifted[7]}}, shifted[7:0]};
      F3_LH:   load_result = {{16{shifted[15]}}, shifted[15:0]};
      F3_LBU:  load_result = {24'd0, shifted[7:0]};
      F3_LHU:  load_result = {16'd0, shifted[15:0]};
      default: load_result = shifted;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - MEM-stage load/store initiator for the data-memory controller
// Purpose: accepts pipeline load/store requests, drives and holds the memory
//          request until mem_ready, returns extended load data, flags illegal
//          requests and bounds every access with a timeout.
// Ports:
//   clk, reset (async, active-low)
//   req_ren, req_wen, req_funct3, req_addr, req_wdata : pipeline request
//   stall, done, load_data, misalign, bus_error       : pipeline response
//   mem (load_store_unit_if.master)                    : memory controller bus
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       req_ren,
  input  logic                       req_wen,
  input  logic [2:0]                 req_funct3,
  input  logic [31:0]                req_addr,
  input  logic [31:0]                req_wdata,
  output logic                       stall,
  output logic                       done,
  output logic [31:0]                load_data,
  output logic                       misalign,
  output logic                       bus_error,
  load_store_unit_if.master          mem
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic [2:0]       lat_funct3;
  logic [1:0]       lat_offset;

  logic             legal;
  logic [3:0]       byte_select;
  logic [31:0]      store_data;
  logic [31:0]      load_result;

  load_store_unit_align u_align (
    .ren         (req_ren),
    .wen         (req_wen),
    .funct3      (req_funct3),
    .offset      (req_addr[1:0]),
    .wdata       (req_wdata),
    .ld_funct3   (lat_funct3),
    .ld_offset   (lat_offset),
    .rdata       (mem.mem_dataout),
    .legal       (legal),
    .byte_select (byte_select),
    .store_data  (store_data),
    .load_result (load_result)
  );

  // cnt holds the number of WAIT cycles already spent without mem_ready.
  assign cnt_next = cnt + CNT_W'(1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state               <= S_IDLE;
      cnt                 <= '0;
      lat_funct3          <= '0;
      lat_offset          <= '0;
      stall               <= 1'b0;
      done                <= 1'b0;
      load_data           <= '0;
      misalign            <= 1'b0;
      bus_error           <= 1'b0;
      mem.mem_address     <= '0;
      mem.mem_datain      <= '0;
      mem.mem_ren         <= 1'b0;
      mem.mem_wen         <= 1'b0;
      mem.mem_byte_select <= '0;
    end else begin
      done      <= 1'b0;
      misalign  <= 1'b0;
      bus_error <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req_ren || req_wen) begin
            if (legal) begin
              lat_funct3          <= req_funct3;
              lat_offset          <= req_addr[1:0];
              mem.mem_address     <= {req_addr[31:2], 2'b00};
              mem.mem_datain      <= store_data;
              mem.mem_byte_select <= byte_select;
              mem.mem_ren         <= req_ren;
              mem.mem_wen         <= req_wen;
              stall               <= 1'b1;
              state               <= S_ISSUE;
            end else begin
              misalign <= 1'b1;
            end
          end
        end
        S_ISSUE: begin
          // The controller sees the request for the first time this cycle,
          // so any mem_ready level now is stale and ignored.
          cnt   <= '0;
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (mem.mem_ready || (cnt_next == CNT_W'(TIMEOUT_CYCLES))) begin
            if (mem.mem_ready) begin
              if (mem.mem_ren) load_data <= load_result;
            end else begin
              bus_error <= 1'b1;
            end
            done        <= 1'b1;
            stall       <= 1'b0;
            mem.mem_ren <= 1'b0;
            mem.mem_wen <= 1'b0;
            cnt         <= '0;
            state       <= S_DONE;
          end else begin
            cnt <= cnt_next;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - scoreboard bench for load_store_unit
module tb_load_store_unit;

  logic        clk;
  logic        reset;
  logic        req_ren;
  logic        req_wen;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        stall;
  logic        done;
  logic [31:0] load_data;
  logic        misalign;
  logic        bus_error;

  load_store_unit_if mem_bus ();

  load_store_unit #(.TIMEOUT_CYCLES(64)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_ren    (req_ren),
    .req_wen    (req_wen),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .stall      (stall),
    .done       (done),
    .load_data  (load_data),
    .misalign   (misalign),
    .bus_error  (bus_error),
    .mem        (mem_bus)
  );

  typedef struct {
    bit          is_mis;
    bit          berr;
    logic [31:0] ld;
    string       name;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   passes = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic expect_resp(input bit is_mis, input bit berr, input logic [31:0] ld, input string name);
    exp_t e;
    e.is_mis = is_mis;
    e.berr   = berr;
    e.ld     = ld;
    e.name   = name;
    sb.push_back(e);
  endtask

  // Monitor: every done or misalign pulse is matched against the oldest expectation.
  always @(negedge clk) begin
    if (reset && (done || misalign)) begin
      if (sb.size() == 0) begin
        checks++;
        $display("FAIL unexpected_response: got done=%0b misalign=%0b expected none", done, misalign);
      end else begin
        mon_e = sb.pop_front();
        chk({mon_e.name, ".misalign"}, {31'd0, misalign}, {31'd0, mon_e.is_mis});
        chk({mon_e.name, ".done"}, {31'd0, done}, {31'd0, !mon_e.is_mis});
        if (!mon_e.is_mis) begin
          chk({mon_e.name, ".bus_error"}, {31'd0, bus_error}, {31'd0, mon_e.berr});
          chk({mon_e.name, ".load_data"}, load_data, mon_e.ld);
        end
      end
    end
  end

  // Present a request for one clock edge; returns at the negedge after that edge.
  task automatic issue(input logic ren, input logic wen, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wd);
    @(negedge clk);
    req_ren    = ren;
    req_wen    = wen;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wd;
    @(negedge clk);
    req_ren = 1'b0;
    req_wen = 1'b0;
  endtask

  // Called in the ISSUE cycle (lat=1). Raises mem_ready at lat==ready_at.
  task automatic wait_done(input int ready_at, output int lat, output int stall_n, output bit stable);
    logic [3:0]  sel0;
    logic [31:0] addr0;
    sel0    = mem_bus.mem_byte_select;
    addr0   = mem_bus.mem_address;
    lat     = 1;
    stall_n = stall ? 1 : 0;
    stable  = 1'b1;
    while (!done && lat < 300) begin
      if (lat == ready_at) mem_bus.mem_ready = 1'b1;
      @(negedge clk);
      lat++;
      if (stall) stall_n++;
      if (!done && (mem_bus.mem_byte_select != sel0 || mem_bus.mem_address != addr0 ||
                    !(mem_bus.mem_ren || mem_bus.mem_wen)))
        stable = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int lat, stall_n;
    bit stable;

    reset = 1'b0;
    req_ren = 1'b0; req_wen = 1'b0; req_funct3 = 3'b000; req_addr = '0; req_wdata = '0;
    mem_bus.mem_ready = 1'b1;
    mem_bus.mem_dataout = '0;

    #2;
    chk("reset.stall", {31'd0, stall}, 32'd0);
    chk("reset.done", {31'd0, done}, 32'd0);
    chk("reset.mem_ren", {31'd0, mem_bus.mem_ren}, 32'd0);
    chk("reset.mem_wen", {31'd0, mem_bus.mem_wen}, 32'd0);
    chk("reset.load_data", load_data, 32'd0);
    chk("reset.byte_select", {28'd0, mem_bus.mem_byte_select}, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    // 1: SW 0x100 0xDEADBEEF, ready already high.
    expect_resp(1'b0, 1'b0, 32'h0, "sw");
    issue(1'b0, 1'b1, 3'b010, 32'h100, 32'hDEADBEEF);
    chk("sw.mem_wen", {31'd0, mem_bus.mem_wen}, 32'd1);
    chk("sw.mem_ren", {31'd0, mem_bus.mem_ren}, 32'd0);
    chk("sw.sel", {28'd0, mem_bus.mem_byte_select}, 32'hF);
    chk("sw.datain", mem_bus.mem_datain, 32'hDEADBEEF);
    chk("sw.address", mem_bus.mem_address, 32'h100);
    chk("sw.stall", {31'd0, stall}, 32'd1);
    wait_done(0, lat, stall_n, stable);
    chk("sw.latency", lat, 32'd3);
    chk("sw.stall_at_done", {31'd0, stall}, 32'd0);
    chk("sw.wen_at_done", {31'd0, mem_bus.mem_wen}, 32'd0);

    // 2: LB / LBU at 0x103.
    mem_bus.mem_dataout = 32'h80FF0000;
    expect_resp(1'b0, 1'b0, 32'hFFFFFF80, "lb");
    issue(1'b1, 1'b0, 3'b000, 32'h103, 32'h0);
    chk("lb.sel", {28'd0, mem_bus.mem_byte_select}, 32'h8);
    chk("lb.address", mem_bus.mem_address, 32'h100);
    wait_done(0, lat, stall_n, stable);
    expect_resp(1'b0, 1'b0, 32'h00000080, "lbu");
    issue(1'b1, 1'b0, 3'b100, 32'h103, 32'h0);
    wait_done(0, lat, stall_n, stable);

    // 3: LH 0x102, five WAIT cycles without ready.
    mem_bus.mem_ready = 1'b0;
    mem_bus.mem_dataout = 32'h80011234;
    expect_resp(1'b0, 1'b0, 32'hFFFF8001, "lh");
    issue(1'b1, 1'b0, 3'b001, 32'h102, 32'h0);
    chk("lh.sel", {28'd0, mem_bus.mem_byte_select}, 32'hC);
    wait_done(7, lat, stall_n, stable);
    chk("lh.stall_cycles", stall_n, 32'd7);
    chk("lh.latency", lat, 32'd8);
    chk("lh.stable", {31'd0, stable}, 32'd1);

    // 4: illegal requests.
    expect_resp(1'b1, 1'b0, 32'h0, "lw_mis");
    issue(1'b1, 1'b0, 3'b010, 32'h101, 32'h0);
    chk("lw_mis.stall", {31'd0, stall}, 32'd0);
    chk("lw_mis.mem_ren", {31'd0, mem_bus.mem_ren}, 32'd0);
    @(negedge clk);
    chk("lw_mis.pulse_end", {31'd0, misalign}, 32'd0);
    chk("lw_mis.mem_ren_after", {31'd0, mem_bus.mem_ren}, 32'd0);
    expect_resp(1'b1, 1'b0, 32'h0, "renwen");
    issue(1'b1, 1'b1, 3'b010, 32'h100, 32'h0);
    chk("renwen.stall", {31'd0, stall}, 32'd0);
    expect_resp(1'b1, 1'b0, 32'h0, "store_f3_100");
    issue(1'b0, 1'b1, 3'b100, 32'h100, 32'h0);
    expect_resp(1'b1, 1'b0, 32'h0, "load_f3_011");
    issue(1'b1, 1'b0, 3'b011, 32'h100, 32'h0);
    @(negedge clk);

    // 5: timeout; load_data keeps the previous load.
    mem_bus.mem_ready = 1'b0;
    expect_resp(1'b0, 1'b1, 32'hFFFF8001, "timeout");
    issue(1'b1, 1'b0, 3'b010, 32'h200, 32'h0);
    wait_done(-1, lat, stall_n, stable);
    chk("timeout.latency", lat, 32'd66);
    chk("timeout.stall_cycles", stall_n, 32'd65);
    chk("timeout.stall_released", {31'd0, stall}, 32'd0);

    // 6: reset in WAIT, then SB 0x2.
    issue(1'b1, 1'b0, 3'b010, 32'h300, 32'h0);
    @(negedge clk);
    chk("rst_wait.mem_ren_before", {31'd0, mem_bus.mem_ren}, 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("rst_wait.mem_ren", {31'd0, mem_bus.mem_ren}, 32'd0);
    chk("rst_wait.stall", {31'd0, stall}, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    mem_bus.mem_ready = 1'b1;
    @(negedge clk);
    chk("rst_wait.load_data", load_data, 32'd0);
    expect_resp(1'b0, 1'b0, 32'h0, "sb");
    issue(1'b0, 1'b1, 3'b000, 32'h2, 32'hAB);
    chk("sb.sel", {28'd0, mem_bus.mem_byte_select}, 32'h4);
    chk("sb.datain", mem_bus.mem_datain, 32'hABABABAB);
    wait_done(0, lat, stall_n, stable);
    chk("sb.latency", lat, 32'd3);

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
